// File: rtl/spi_reg_bank.sv
// spi_reg_bank: SPI mode-0 peripheral that decodes 16-bit write frames into
// a bank of 8-bit control registers feeding the output/PWM stage.
// Optional feature: define SPI_READBACK_EN to enable register reads on cipo.
module spi_reg_bank #(
    parameter int unsigned NUM_REGS    = 5,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic       cipo,
    output logic [7:0] en_reg_out,
    output logic [7:0] en_reg_uio,
    output logic [7:0] pwm_en_out,
    output logic [7:0] pwm_en_uio,
    output logic [7:0] pwm_duty,
    output logic       frame_err
);

    localparam int unsigned CNT_W     = 5;
    localparam int unsigned NUM_STORE = (NUM_REGS > 5) ? NUM_REGS : 5;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(16);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(17);
    localparam logic [6:0] NUM_REGS_A = 7'(NUM_REGS);
`ifdef SPI_READBACK_EN
    localparam logic READ_OK = 1'b1;
`else
    localparam logic READ_OK = 1'b0;
`endif

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] copi_sync_q, copi_sync_d;
    logic [SYNC_STAGES-1:0] ncs_sync_q, ncs_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic                   ncs_prev_q, ncs_prev_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [15:0]            shift_q, shift_d;
    logic [7:0]             regs_q [NUM_STORE];
    logic [7:0]             regs_d [NUM_STORE];
    logic                   frame_err_q, frame_err_d;

    logic sclk_s, copi_s, ncs_s;
    logic sclk_rise, ncs_rise, ncs_fall;
    logic addr_valid, frame_valid;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign copi_s    = copi_sync_q[SYNC_STAGES-1];
    assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign ncs_rise  = ncs_s & ~ncs_prev_q;
    assign ncs_fall  = ~ncs_s & ncs_prev_q;

    assign addr_valid  = (shift_q[14:8] < NUM_REGS_A);
    assign frame_valid = (cnt_q == CNT_FULL) && addr_valid && (shift_q[15] | READ_OK);

    // Input synchronizers plus one delayed copy for edge detection.
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        copi_sync_d = {copi_sync_q[SYNC_STAGES-2:0], copi};
        ncs_sync_d  = {ncs_sync_q[SYNC_STAGES-2:0], ncs};
        sclk_prev_d = sclk_s;
        ncs_prev_d  = ncs_s;
    end

    // Frame capture, commit decode and register update.
    always_comb begin
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        regs_d      = regs_q;
        frame_err_d = 1'b0;
        if (ncs_fall) begin
            cnt_d   = '0;
            shift_d = '0;
        end else if (ncs_rise) begin
            cnt_d = '0;
            if (frame_valid) begin
                if (shift_q[15]) begin
                    for (int unsigned i = 0; i < NUM_REGS; i++) begin
                        if (shift_q[14:8] == 7'(i)) regs_d[i] = shift_q[7:0];
                    end
                end
            end else begin
                frame_err_d = 1'b1;
            end
        end else if (!ncs_s && sclk_rise) begin
            shift_d = {shift_q[14:0], copi_s};
            if (cnt_q != CNT_SAT) cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers with synchronous reset to idle line levels.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q <= '0;
            copi_sync_q <= '0;
            ncs_sync_q  <= '1;
            sclk_prev_q <= 1'b0;
            ncs_prev_q  <= 1'b1;
            cnt_q       <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            for (int unsigned i = 0; i < NUM_STORE; i++) regs_q[i] <= 8'h00;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            copi_sync_q <= copi_sync_d;
            ncs_sync_q  <= ncs_sync_d;
            sclk_prev_q <= sclk_prev_d;
            ncs_prev_q  <= ncs_prev_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            regs_q      <= regs_d;
        end
    end

`ifdef SPI_READBACK_EN
    logic       cipo_q, cipo_d;
    logic       sclk_fall;
    logic [7:0] hdr;
    logic [7:0] rd_sel;

    assign sclk_fall = ~sclk_s & sclk_prev_q;

    // Read data: header sits in the low bits of the shift register once 8+ bits are in.
    always_comb begin
        cipo_d = cipo_q;
        hdr    = 8'(shift_q >> (cnt_q - CNT_W'(8)));
        rd_sel = 8'h00;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (hdr[6:0] == 7'(i)) rd_sel = regs_q[i];
        end
        if (ncs_s) begin
            cipo_d = 1'b0;
        end else if (sclk_fall) begin
            if ((cnt_q >= CNT_W'(8)) && (cnt_q < CNT_FULL) && !hdr[7] && (hdr[6:0] < NUM_REGS_A))
                cipo_d = rd_sel[3'(CNT_W'(15) - cnt_q)];
            else
                cipo_d = 1'b0;
        end
    end

    // Registered read data output.
    always_ff @(posedge clk) begin
        if (rst) cipo_q <= 1'b0;
        else     cipo_q <= cipo_d;
    end

    assign cipo = cipo_q;
`else
    assign cipo = 1'b0;
`endif

    assign en_reg_out = regs_q[0];
    assign en_reg_uio = regs_q[1];
    assign pwm_en_out = regs_q[2];
    assign pwm_en_uio = regs_q[3];
    assign pwm_duty   = regs_q[4];
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
// tb_spi_reg_bank: drives SPI frames (directed + random) and checks register
// outputs, commit latency, frame_err pulses and cipo against a register model.
module tb_spi_reg_bank;

    logic clk = 1'b0;
    logic rst, sclk, copi, ncs;
    logic cipo, frame_err;
    logic [7:0] en_reg_out, en_reg_uio, pwm_en_out, pwm_en_uio, pwm_duty;

    spi_reg_bank dut (
        .clk(clk), .rst(rst), .sclk(sclk), .copi(copi), .ncs(ncs), .cipo(cipo),
        .en_reg_out(en_reg_out), .en_reg_uio(en_reg_uio), .pwm_en_out(pwm_en_out),
        .pwm_en_uio(pwm_en_uio), .pwm_duty(pwm_duty), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int err_cnt  = 0;
    logic [7:0] model [5];

    // Count cycles frame_err is high; a legal pulse contributes exactly one.
    always @(negedge clk) if (frame_err === 1'b1) err_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_r0"}, 32'(en_reg_out), 32'(model[0]));
        check({tag, "_r1"}, 32'(en_reg_uio), 32'(model[1]));
        check({tag, "_r2"}, 32'(pwm_en_out), 32'(model[2]));
        check({tag, "_r3"}, 32'(pwm_en_uio), 32'(model[3]));
        check({tag, "_r4"}, 32'(pwm_duty),   32'(model[4]));
    endtask

    // Clock nbits of value out MSB first, checking cipo during the data phase.
    task automatic clock_bits(input int nbits, input logic [31:0] value);
        logic [7:0] hdr;
        logic [7:0] rdat;
        bit rd;
        hdr  = (nbits >= 8) ? 8'(value >> (nbits - 8)) : 8'h00;
        rd   = 1'b0;
        rdat = 8'h00;
`ifdef SPI_READBACK_EN
        rd = (hdr[7] == 1'b0) && (hdr[6:0] < 7'd5);
        if (rd) rdat = model[hdr[2:0]];
`endif
        for (int k = 0; k < nbits; k++) begin
            copi = value[nbits-1-k];
            tick(4);
            if (k >= 8 && k <= 15)
                check("cipo_bit", 32'(cipo), rd ? 32'(rdat[15-k]) : 32'd0);
            sclk = 1'b1;
            tick(4);
            sclk = 1'b0;
        end
        tick(4);
    endtask

    // Raise ncs, check commit latency, frame_err and idle cipo against the model.
    task automatic commit(input int nbits, input logic [31:0] value);
        logic rw;
        logic [6:0] addr;
        bit ok, valid, wr, rdok;
        int e0;
        rw    = value[15];
        addr  = value[14:8];
        ok    = (nbits == 16);
        valid = (addr < 7'd5);
        wr    = ok && rw && valid;
        rdok  = 1'b0;
`ifdef SPI_READBACK_EN
        rdok  = ok && !rw && valid;
`endif
        e0  = err_cnt;
        ncs = 1'b1;
        tick(2);
        check_regs("pre_commit");
        tick(1);
        if (wr) model[addr[2:0]] = value[7:0];
        check_regs("post_commit");
        tick(6);
        check("frame_err", 32'(err_cnt - e0), (wr || rdok) ? 32'd0 : 32'd1);
        check("cipo_idle", 32'(cipo), 32'd0);
    endtask

    task automatic frame(input int nbits, input logic [31:0] value);
        ncs = 1'b0;
        tick(4);
        clock_bits(nbits, value);
        commit(nbits, value);
    endtask

    initial begin
        int e0;
        logic [15:0] word;
        int sel, nb;
        logic [31:0] val;

        rst = 1'b1; sclk = 1'b0; copi = 1'b0; ncs = 1'b1;
        for (int i = 0; i < 5; i++) model[i] = 8'h00;
        tick(3);
        rst = 1'b0;
        tick(1);
        check_regs("reset");
        check("reset_cipo", 32'(cipo), 32'd0);
        check("reset_ferr", 32'(frame_err), 32'd0);

        // Directed writes, invalid address, short and long frames.
        frame(16, 32'h80F0);
        check("en_reg_out_f0", 32'(en_reg_out), 32'hF0);
        frame(16, 32'h8480);
        check("pwm_duty_80", 32'(pwm_duty), 32'h80);
        frame(16, 32'h85AA);
        frame(12, 32'h0824);
        frame(18, 32'h20AA9);

        // sclk activity with ncs high must be ignored.
        e0 = err_cnt;
        for (int i = 0; i < 16; i++) begin
            copi = i[0];
            sclk = 1'b1; tick(4);
            sclk = 1'b0; tick(4);
        end
        tick(6);
        check_regs("ncs_high_sclk");
        check("ncs_high_ferr", 32'(err_cnt - e0), 32'd0);
        frame(16, 32'h813C);
        check("en_reg_uio_3c", 32'(en_reg_uio), 32'h3C);

        // Reset after bit 9 of a write to addr 0x02.
        ncs = 1'b0;
        tick(4);
        clock_bits(9, 32'h825A >> 7);
        e0 = err_cnt;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) model[i] = 8'h00;
        tick(1);
        check_regs("mid_reset");
        check("mid_reset_ferr", 32'(err_cnt - e0), 32'd0);
        clock_bits(7, 32'h825A & 32'h7F);
        commit(7, 32'h825A & 32'h7F);
        check("pwm_en_out_0", 32'(pwm_en_out), 32'h00);

        // Write then read back addr 0x03.
        frame(16, 32'h83A5);
        frame(16, 32'h0300);

        // Randomized frames against the model.
        for (int n = 0; n < 30; n++) begin
            word = {1'($urandom_range(0, 1)), 7'($urandom_range(0, 7)), 8'($urandom)};
            sel  = int'($urandom_range(0, 9));
            if (sel == 0) begin
                nb = 12; val = 32'(word >> 4);
            end else if (sel == 1) begin
                nb = 18; val = (32'(word) << 2) | 32'($urandom_range(0, 3));
            end else if (sel == 2) begin
                nb = 15; val = 32'(word >> 1);
            end else begin
                nb = 16; val = 32'(word);
            end
            frame(nb, val);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
